csa_accumulator: RTL

//   Streaming multi-operand accumulator in carry-save form, directly upstream of the final

---
 rtl/csa_accumulator_if.sv | 64 ++++++
 rtl/csa_accumulator.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/csa_accumulator_if.sv
// ---------------------------------------------------------------------------
// csa_accumulator_if
//   Bundles the operand stream and the result stream of csa_accumulator.
//
//   Handshake rule (both streams): a beat transfers on a rising clock edge
//   where valid and ready are both 1. The producer holds its payload stable
//   while valid=1 and ready=0. The accumulator never makes in_ready depend on
//   out_ready combinationally.
//
//   Signals
//     in_valid / in_ready / in_data / in_last : operand stream into the block
//     out_valid / out_ready                   : result pair out of the block
//     out_sum / out_carry                     : redundant result pair
//     out_count                               : operands in the group
//     out_forced                              : group closed by the size limit
//
//   Modports
//     slave  : the accumulator's view
//     master : the environment's view (operand source + result sink)
// ---------------------------------------------------------------------------
interface csa_accumulator_if #(
    parameter int BIT_WIDTH    = 32,
    parameter int MAX_OPERANDS = 16
);
    localparam int CNT_W = $clog2(MAX_OPERANDS + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] in_data;
    logic                 in_last;

    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] out_sum;
    logic [BIT_WIDTH-1:0] out_carry;
    logic [CNT_W-1:0]     out_count;
    logic                 out_forced;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_sum,
        output out_carry,
        output out_count,
        output out_forced
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_sum,
        input  out_carry,
        input  out_count,
        input  out_forced
    );
endinterface

// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// csa_accumulator
//   Streaming multi-operand accumulator kept in carry-save form. Each accepted
//   operand is folded into the (sum, carry) pair with one row of 3:2 full
//   adders, so there is no carry propagation in the loop. The closed group is
//   presented as a redundant pair for a downstream carry-propagate adder:
//   total = out_sum + out_carry (carry-in 0), modulo 2^BIT_WIDTH.
//
//   Ports
//     clk     : clock, rising edge
//     rst     : asynchronous, active-high reset
//     bus     : csa_accumulator_if.slave (operand stream in, result pair out)
//     state_o : current FSM state, for debug/observation
//
//   FSM
//     IDLE  : no operand held, in_ready=1
//     ACCUM : one or more operands held, in_ready=1
//     HOLD  : result presented, out_valid=1, in_ready=0
//   A group closes on the beat carrying in_last, or on the beat that brings
//   the count to MAX_OPERANDS (forced close). HOLD leaves on out_ready; there
//   is no bypass, so a new group starts the cycle after the pop.
// ---------------------------------------------------------------------------
module csa_accumulator #(
    parameter int BIT_WIDTH    = 32,
    parameter int MAX_OPERANDS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    csa_accumulator_if.slave     bus,
    output logic [1:0]           state_o
);
    localparam int CNT_W = $clog2(MAX_OPERANDS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPERANDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]           state_q,  state_d;
    logic [BIT_WIDTH-1:0] sum_q,    sum_d;
    logic [BIT_WIDTH-1:0] carry_q,  carry_d;
    logic [CNT_W-1:0]     count_q,  count_d;
    logic                 forced_q, forced_d;

    logic                 accept;
    logic                 close_group;
    logic [CNT_W-1:0]     count_inc;
    logic [BIT_WIDTH-1:0] csa_sum;
    logic [BIT_WIDTH-2:0] csa_maj;
    logic [BIT_WIDTH-1:0] csa_carry;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    assign bus.in_ready  = (state_q != S_HOLD);
    assign bus.out_valid = (state_q == S_HOLD);
    assign accept        = bus.in_valid & bus.in_ready;

    // -----------------------------------------------------------------------
    // 3:2 compressor row. In IDLE sum_q and carry_q are zero, so the first
    // operand lands as s'=d, c'=0 with no special case. The majority MSB
    // would carry out of the word and is simply never formed.
    // -----------------------------------------------------------------------
    assign csa_sum   = sum_q ^ carry_q ^ bus.in_data;
    assign csa_maj   = (sum_q[BIT_WIDTH-2:0]   & carry_q[BIT_WIDTH-2:0])
                     | (sum_q[BIT_WIDTH-2:0]   & bus.in_data[BIT_WIDTH-2:0])
                     | (carry_q[BIT_WIDTH-2:0] & bus.in_data[BIT_WIDTH-2:0]);
    assign csa_carry = {csa_maj, 1'b0};

    assign count_inc   = count_q + CNT_W'(1);
    // In IDLE count_q is 0, so count_inc reaches MAX_CNT only when
    // MAX_OPERANDS is 1: a one-operand group always closes immediately.
    assign close_group = bus.in_last | (count_inc == MAX_CNT);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        count_d  = count_q;
        forced_d = forced_q;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept) begin
                    sum_d   = csa_sum;
                    carry_d = csa_carry;
                    count_d = count_inc;
                    if (close_group) begin
                        state_d  = S_HOLD;
                        // in_last wins over the size limit on the same beat.
                        forced_d = ~bus.in_last;
                    end else begin
                        state_d  = S_ACCUM;
                    end
                end
            end

            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d  = S_IDLE;
                    sum_d    = '0;
                    carry_d  = '0;
                    count_d  = '0;
                    forced_d = 1'b0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                sum_d    = '0;
                carry_d  = '0;
                count_d  = '0;
                forced_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sum_q    <= '0;
            carry_q  <= '0;
            count_q  <= '0;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            forced_q <= forced_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs come straight from registers, so they are stable in HOLD.
    // -----------------------------------------------------------------------
    assign bus.out_sum    = sum_q;
    assign bus.out_carry  = carry_q;
    assign bus.out_count  = count_q;
    assign bus.out_forced = forced_q;
    assign state_o        = state_q;

endmodule
